// File: rtl/bcd_scan_display_if.sv
// Digit-source / display bus for bcd_scan_display: BCD digits and load request in,
// scanned segment/anode drive and status pulses out.
interface bcd_scan_display_if;
   logic [3:0] D5, D4, D3, D2, D1;
   logic       load;
   logic       blank_lz;
   logic [6:0] seg;
   logic [4:0] an;
   logic       load_ack;
   logic       frame_done;

   modport master (
      output D5, D4, D3, D2, D1, load, blank_lz,
      input  seg, an, load_ack, frame_done
   );

   modport slave (
      input  D5, D4, D3, D2, D1, load, blank_lz,
      output seg, an, load_ack, frame_done
   );
endinterface

// File: rtl/bcd_scan_display.sv
// Five-digit multiplexed 7-segment driver: staging/shadow digit buffers swapped only at
// frame wrap, per-digit divider, decode with blank/dash codes and leading-zero suppression.
module bcd_scan_display #(
   parameter int unsigned SCAN_DIV = 1000
) (
   input logic              clk,
   input logic              rst_n,
   bcd_scan_display_if.slave bus
);

   localparam logic [15:0] TERM = 16'(SCAN_DIV - 1);

   logic [4:0][3:0] r_staging;
   logic [4:0][3:0] r_shadow;
   logic            r_pending;
   logic [15:0]     r_cnt;
   logic [2:0]      r_idx;
   logic [6:0]      r_seg;
   logic [4:0]      r_an;
   logic            r_load_ack;
   logic            r_frame_done;

   logic [4:0][3:0] w_din;
   logic            w_term;
   logic            w_wrap;
   logic [4:0]      w_lz_mask;
   logic [3:0]      w_digit;
   logic [6:0]      w_seg_next;

   function automatic logic [6:0] seg_decode(input logic [3:0] v);
      case (v)
         4'd0:    seg_decode = 7'h3F;
         4'd1:    seg_decode = 7'h06;
         4'd2:    seg_decode = 7'h5B;
         4'd3:    seg_decode = 7'h4F;
         4'd4:    seg_decode = 7'h66;
         4'd5:    seg_decode = 7'h6D;
         4'd6:    seg_decode = 7'h7D;
         4'd7:    seg_decode = 7'h07;
         4'd8:    seg_decode = 7'h7F;
         4'd9:    seg_decode = 7'h6F;
         4'hF:    seg_decode = 7'h00;
         default: seg_decode = 7'h40;
      endcase
   endfunction

   // Walk down from D5: zeros are suppressed while everything above is zero or blank;
   // any shown value (1..9 or dash) ends suppression. D1 is never masked.
   function automatic logic [4:0] lz_mask(input logic [4:0][3:0] d);
      logic sup;
      lz_mask = 5'b00000;
      sup     = 1'b1;
      for (int k = 4; k >= 1; k--) begin
         if (sup && d[k] == 4'd0)
            lz_mask[k] = 1'b1;
         else if (d[k] != 4'hF)
            sup = 1'b0;
      end
   endfunction

   assign w_din      = {bus.D5, bus.D4, bus.D3, bus.D2, bus.D1};
   assign w_term     = (r_cnt == TERM);
   assign w_wrap     = w_term && (r_idx == 3'd4);
   assign w_lz_mask  = lz_mask(r_shadow);
   assign w_digit    = r_shadow[r_idx];
   assign w_seg_next = (bus.blank_lz && w_lz_mask[r_idx]) ? 7'h00 : seg_decode(w_digit);

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         r_staging    <= {5{4'hF}};
         r_shadow     <= {5{4'hF}};
         r_pending    <= 1'b0;
         r_cnt        <= 16'd0;
         r_idx        <= 3'd0;
         r_seg        <= 7'h00;
         r_an         <= 5'b00001;
         r_load_ack   <= 1'b0;
         r_frame_done <= 1'b0;
      end else begin
         // Outputs reflect the pre-edge index/shadow, so an and seg always move together.
         r_seg        <= w_seg_next;
         r_an         <= 5'b00001 << r_idx;
         r_frame_done <= w_wrap;
         r_load_ack   <= w_wrap && (r_pending || bus.load);

         if (w_term) begin
            r_cnt <= 16'd0;
            r_idx <= (r_idx == 3'd4) ? 3'd0 : r_idx + 3'd1;
         end else begin
            r_cnt <= r_cnt + 16'd1;
         end

         // A load landing on the wrap edge bypasses staging and wins over an older pending set.
         if (w_wrap && bus.load) begin
            r_shadow  <= w_din;
            r_pending <= 1'b0;
         end else if (w_wrap && r_pending) begin
            r_shadow  <= r_staging;
            r_pending <= 1'b0;
         end else if (bus.load) begin
            r_staging <= w_din;
            r_pending <= 1'b1;
         end
      end
   end

   assign bus.seg        = r_seg;
   assign bus.an         = r_an;
   assign bus.load_ack   = r_load_ack;
   assign bus.frame_done = r_frame_done;

endmodule

// File: tb/tb_bcd_scan_display.sv
// Scoreboard bench for bcd_scan_display: expected per-digit segment codes are queued when a
// digit set is loaded and popped as the DUT scans each digit of the displayed frame.
module tb_bcd_scan_display;

   localparam int SD    = 2;
   localparam int FRAME = 5 * SD;

   logic clk = 1'b0;
   logic rst_n;
   int   vectors = 0;
   int   miscompares = 0;
   logic [6:0] exp_q[$];

   bcd_scan_display_if bus ();

   bcd_scan_display #(.SCAN_DIV(SD)) dut (
      .clk   (clk),
      .rst_n (rst_n),
      .bus   (bus)
   );

   always #5 clk = ~clk;

   task automatic do_load(input logic [3:0] d5, d4, d3, d2, d1);
      bus.D5 = d5; bus.D4 = d4; bus.D3 = d3; bus.D2 = d2; bus.D1 = d1;
      bus.load = 1'b1;
      @(negedge clk);
      bus.load = 1'b0;
   endtask

   task automatic push5(input logic [6:0] e0, e1, e2, e3, e4);
      exp_q.push_back(e0); exp_q.push_back(e1); exp_q.push_back(e2);
      exp_q.push_back(e3); exp_q.push_back(e4);
   endtask

   task automatic wait_fd();
      bit seen = 0;
      for (int i = 0; i < FRAME + 5 && !seen; i++) begin
         @(negedge clk);
         if (bus.frame_done === 1'b1) seen = 1;
      end
      vectors++;
      if (!seen) begin
         miscompares++;
         $display("FAIL wait_fd: frame_done not seen within %0d cycles", FRAME + 5);
      end
   endtask

   // Runs to the next wrap sample, demanding no ack before it and exp_ack at it.
   task automatic wait_wrap(input logic exp_ack, input bit chk_blank);
      bit done = 0;
      for (int i = 0; i < 4 * FRAME && !done; i++) begin
         @(negedge clk);
         vectors++;
         if (bus.frame_done === 1'b1) begin
            done = 1;
            if (bus.load_ack !== exp_ack) begin
               miscompares++;
               $display("FAIL wrap_ack: load_ack=%b required %b", bus.load_ack, exp_ack);
            end
         end else begin
            if (bus.load_ack !== 1'b0) begin
               miscompares++;
               $display("FAIL early_ack: load_ack=%b required 0 before wrap", bus.load_ack);
            end
            if (chk_blank && bus.seg !== 7'h00) begin
               miscompares++;
               $display("FAIL mid_frame_seg: seg=%h required 00 (shadow must not change)", bus.seg);
            end
         end
      end
      if (!done) begin
         vectors++;
         miscompares++;
         $display("FAIL wrap_timeout: no frame_done within %0d cycles", 4 * FRAME);
      end
   endtask

   // Called at the wrap sample; checks the following full frame against the queue.
   task automatic scan_frame();
      logic [6:0] e;
      if (exp_q.size() < 5) begin
         vectors++;
         miscompares++;
         $display("FAIL scoreboard: only %0d entries queued, required 5", exp_q.size());
         exp_q.delete();
         return;
      end
      for (int k = 0; k < 5; k++) begin
         e = exp_q.pop_front();
         for (int c = 0; c < SD; c++) begin
            @(negedge clk);
            vectors++;
            if (bus.an !== (5'b00001 << k) || bus.seg !== e) begin
               miscompares++;
               $display("FAIL scan digit%0d: an=%b seg=%h required an=%b seg=%h",
                        k + 1, bus.an, bus.seg, 5'b00001 << k, e);
            end
            vectors++;
            if (bus.load_ack !== 1'b0 || bus.frame_done !== (k == 4 && c == SD - 1)) begin
               miscompares++;
               $display("FAIL scan_pulses digit%0d: load_ack=%b frame_done=%b required 0/%b",
                        k + 1, bus.load_ack, bus.frame_done, (k == 4 && c == SD - 1));
            end
         end
      end
   endtask

   task automatic test_reset();
      int exp_i;
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      vectors++;
      if (bus.an !== 5'b00001 || bus.seg !== 7'h00 || bus.load_ack !== 1'b0 || bus.frame_done !== 1'b0) begin
         miscompares++;
         $display("FAIL reset_state: an=%b seg=%h ack=%b fd=%b required 00001/00/0/0",
                  bus.an, bus.seg, bus.load_ack, bus.frame_done);
      end
      rst_n = 1'b1;
      for (int n = 1; n <= 2 * FRAME; n++) begin
         @(negedge clk);
         exp_i = ((n - 1) / SD) % 5;
         vectors++;
         if (bus.an !== (5'b00001 << exp_i) || bus.seg !== 7'h00 ||
             bus.frame_done !== (n % FRAME == 0)) begin
            miscompares++;
            $display("FAIL reset_walk n=%0d: an=%b seg=%h fd=%b required %b/00/%b",
                     n, bus.an, bus.seg, bus.frame_done, 5'b00001 << exp_i, (n % FRAME == 0));
         end
      end
   endtask

   task automatic test_load_mid();
      bus.blank_lz = 1'b0;
      wait_fd();
      repeat (2) @(negedge clk);
      do_load(4'd0, 4'd1, 4'd2, 4'd3, 4'd4);
      push5(7'h66, 7'h4F, 7'h5B, 7'h06, 7'h3F);
      wait_wrap(1'b1, 1'b1);
      scan_frame();
   endtask

   task automatic test_leading_zeros();
      wait_fd();
      repeat (2) @(negedge clk);
      bus.blank_lz = 1'b1;
      do_load(4'd0, 4'd0, 4'hF, 4'd0, 4'd7);
      push5(7'h07, 7'h00, 7'h00, 7'h00, 7'h00);
      wait_wrap(1'b1, 1'b0);
      scan_frame();
      bus.blank_lz = 1'b0;
      push5(7'h07, 7'h3F, 7'h00, 7'h3F, 7'h3F);
      scan_frame();
   endtask

   task automatic test_illegal();
      bus.blank_lz = 1'b1;
      wait_fd();
      @(negedge clk);
      do_load(4'd0, 4'd0, 4'hA, 4'd0, 4'd0);
      push5(7'h3F, 7'h3F, 7'h40, 7'h00, 7'h00);
      wait_wrap(1'b1, 1'b0);
      scan_frame();
      bus.blank_lz = 1'b0;
   endtask

   task automatic test_double_load();
      wait_fd();
      @(negedge clk);
      do_load(4'd1, 4'd1, 4'd1, 4'd1, 4'd1);
      repeat (2) @(negedge clk);
      do_load(4'd9, 4'd9, 4'd9, 4'd9, 4'd9);
      push5(7'h6F, 7'h6F, 7'h6F, 7'h6F, 7'h6F);
      wait_wrap(1'b1, 1'b0);
      scan_frame();
   endtask

   task automatic test_back_to_back();
      wait_fd();
      repeat (FRAME - 1) @(negedge clk);
      do_load(4'd5, 4'd6, 4'd7, 4'd8, 4'd9);
      vectors++;
      if (bus.load_ack !== 1'b1 || bus.frame_done !== 1'b1) begin
         miscompares++;
         $display("FAIL bypass_ack: load_ack=%b frame_done=%b required 1/1",
                  bus.load_ack, bus.frame_done);
      end
      push5(7'h6F, 7'h7F, 7'h07, 7'h7D, 7'h6D);
      scan_frame();
   endtask

   task automatic test_reset_pending();
      wait_fd();
      repeat (2) @(negedge clk);
      do_load(4'd3, 4'd3, 4'd3, 4'd3, 4'd3);
      rst_n = 1'b0;
      repeat (2) @(negedge clk);
      rst_n = 1'b1;
      for (int n = 0; n < 2 * FRAME + 2; n++) begin
         @(negedge clk);
         vectors++;
         if (bus.load_ack !== 1'b0 || bus.seg !== 7'h00) begin
            miscompares++;
            $display("FAIL reset_pending n=%0d: load_ack=%b seg=%h required 0/00",
                     n, bus.load_ack, bus.seg);
         end
      end
   endtask

   initial begin
      rst_n        = 1'b0;
      bus.load     = 1'b0;
      bus.blank_lz = 1'b0;
      bus.D5 = 4'd0; bus.D4 = 4'd0; bus.D3 = 4'd0; bus.D2 = 4'd0; bus.D1 = 4'd0;
      test_reset();
      test_load_mid();
      test_leading_zeros();
      test_illegal();
      test_double_load();
      test_back_to_back();
      test_reset_pending();
      vectors++;
      if (exp_q.size() != 0) begin
         miscompares++;
         $display("FAIL scoreboard_leftover: %0d entries left, required 0", exp_q.size());
      end
      $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
      $finish;
   end

endmodule
